// File: rtl/can_frame_writer.sv
// Avalon-MM master that writes one CAN 2.0A frame into a BasicCAN controller.
// Define CAN_FRAME_WRITER_TIMEOUT_EN to bound the status polling with MAX_POLLS.
module can_frame_writer #(
    parameter int MAX_POLLS = 255
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [10:0] frame_id,
    input  logic        frame_rtr,
    input  logic [3:0]  frame_dlc,
    input  logic [63:0] frame_data,
    output logic [7:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic        avm_read,
    output logic [7:0]  avm_writedata,
    input  logic [7:0]  avm_readdata,
    input  logic        avm_waitrequest_n,
    output logic        busy,
    output logic        tx_done,
    output logic        tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_POLL_GAP,
        S_LOAD,
        S_CMD,
        S_DONE
    } state_t;

    state_t      state;
    logic [10:0] id_q;
    logic        rtr_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic [3:0]  idx;
    logic [3:0]  nbytes;
    logic [3:0]  last_idx;
    logic [2:0]  bsel;
    logic [7:0]  load_addr;
    logic [7:0]  load_byte;
    logic        ack;
    logic        unused_status;

    assign ack           = avm_chipselect & avm_waitrequest_n;
    assign unused_status = ^{avm_readdata[7:3], avm_readdata[1:0]};

    // idx 0 = identifier, 1 = control byte, 2.. = data bytes
    always_comb begin
        nbytes    = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
        last_idx  = nbytes + 4'd1;
        bsel      = 3'(idx - 4'd2);
        load_addr = 8'd10 + {4'd0, idx};
        load_byte = data_q[{bsel, 3'b000} +: 8];
        if (idx == 4'd0)
            load_byte = id_q[10:3];
        else if (idx == 4'd1)
            load_byte = {id_q[2:0], rtr_q, dlc_q};
    end

`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
    logic [7:0] polls;
`else
    // Constant low for every legal MAX_POLLS.
    assign tx_err = (MAX_POLLS < 1);
`endif

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state          <= S_IDLE;
            frame_ready    <= 1'b1;
            busy           <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= 8'd0;
            avm_writedata  <= 8'd0;
            tx_done        <= 1'b0;
            id_q           <= 11'd0;
            rtr_q          <= 1'b0;
            dlc_q          <= 4'd0;
            data_q         <= 64'd0;
            idx            <= 4'd0;
`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
            polls          <= 8'd0;
            tx_err         <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
            tx_err  <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (frame_valid) begin
                        id_q           <= frame_id;
                        rtr_q          <= frame_rtr;
                        dlc_q          <= frame_dlc;
                        data_q         <= frame_data;
                        frame_ready    <= 1'b0;
                        busy           <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= 8'd2;
                        state          <= S_POLL;
`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
                        polls          <= 8'd0;
`endif
                    end
                end
                S_POLL: begin
                    if (ack) begin
                        avm_chipselect <= 1'b0;
                        avm_read       <= 1'b0;
                        if (avm_readdata[2]) begin
                            idx   <= 4'd0;
                            state <= S_LOAD;
                        end else begin
                            state <= S_POLL_GAP;
`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
                            polls <= polls + 8'd1;
                            if (polls + 8'd1 == 8'(MAX_POLLS))
                                tx_err <= 1'b1;
`endif
                        end
                    end
                end
                S_POLL_GAP: begin
`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
                    if (tx_err) begin
                        busy        <= 1'b0;
                        frame_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        avm_chipselect <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= 8'd2;
                        state          <= S_POLL;
                    end
`else
                    avm_chipselect <= 1'b1;
                    avm_read       <= 1'b1;
                    avm_address    <= 8'd2;
                    state          <= S_POLL;
`endif
                end
                S_LOAD: begin
                    if (!avm_chipselect) begin
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_address    <= load_addr;
                        avm_writedata  <= load_byte;
                    end else if (ack) begin
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                        idx            <= idx + 4'd1;
                        if (idx == last_idx)
                            state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (!avm_chipselect) begin
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_address    <= 8'd1;
                        avm_writedata  <= 8'h01;
                    end else if (ack) begin
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                        tx_done        <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy        <= 1'b0;
                    frame_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_frame_writer.sv
// Bench for can_frame_writer: 1-cycle-ack slave, per-cycle trace model.
// Timeout test runs when CAN_FRAME_WRITER_TIMEOUT_EN is defined.
module tb_can_frame_writer;

`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
    localparam int MAXP  = 5;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAXP  = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        frame_valid;
    logic        frame_ready;
    logic [10:0] frame_id;
    logic        frame_rtr;
    logic [3:0]  frame_dlc;
    logic [63:0] frame_data;
    logic [7:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [7:0]  avm_writedata;
    logic [7:0]  avm_readdata;
    logic        avm_waitrequest_n;
    logic        busy;
    logic        tx_done;
    logic        tx_err;

    can_frame_writer #(.MAX_POLLS(MAXP)) dut (
        .csi_clk          (clk),
        .rsi_reset_n      (rst_n),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .frame_id         (frame_id),
        .frame_rtr        (frame_rtr),
        .frame_dlc        (frame_dlc),
        .frame_data       (frame_data),
        .avm_address      (avm_address),
        .avm_chipselect   (avm_chipselect),
        .avm_write        (avm_write),
        .avm_read         (avm_read),
        .avm_writedata    (avm_writedata),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest_n(avm_waitrequest_n),
        .busy             (busy),
        .tx_done          (tx_done),
        .tx_err           (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model output: expected access list for the current frame
    bit         exp_wr[$];
    logic [7:0] exp_addr[$];
    logic [7:0] exp_data[$];
    bit         exp_to;
    int         exp_len;

    logic [7:0]  stat_q[$];
    logic [15:0] wlog[$];
    bit          spur = 1'b0;
    bit          seen = 1'b0;
    bit          track = 1'b0;
    bit          pend = 1'b0;
    int          cyc;
    int          done_cyc;
    int          err_cnt;
    int          rcount;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic void chk_log(input string nm, input logic [15:0] e[$]);
        chk({nm, "_nwrites"}, 64'(wlog.size()), 64'(e.size()));
        foreach (e[i])
            if (i < wlog.size())
                chk({nm, "_write"}, 64'(wlog[i]), 64'(e[i]));
    endfunction

    function automatic void push_acc(input bit w, input int a, input int d);
        exp_wr.push_back(w);
        exp_addr.push_back(8'(a));
        exp_data.push_back(8'(d));
    endfunction

    // Reads until TBS is seen (or the poll budget runs out), then the writes.
    function automatic void build(input logic [10:0] id, input bit rtr,
                                  input logic [3:0] dlc, input logic [63:0] data);
        int n;
        int fails;
        int i;
        bit ok;
        logic [7:0] s;
        exp_wr.delete();
        exp_addr.delete();
        exp_data.delete();
        n = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
        fails = 0;
        ok = 1'b0;
        exp_to = 1'b0;
        i = 0;
        while (!ok && !exp_to && i < 1000) begin
            s = (i < stat_q.size()) ? stat_q[i] : 8'h00;
            push_acc(1'b0, 2, 0);
            if (s[2]) ok = 1'b1;
            else begin
                fails++;
                if (TO_EN && fails == MAXP) exp_to = 1'b1;
            end
            i++;
        end
        if (ok) begin
            push_acc(1'b1, 10, int'(id >> 3));
            push_acc(1'b1, 11, int'({id[2:0], rtr, dlc}));
            for (int b = 0; b < n; b++)
                push_acc(1'b1, 12 + b, int'((data >> (8 * b)) & 64'hFF));
            push_acc(1'b1, 1, 1);
        end
        exp_len = 3 * exp_wr.size();
    endfunction

    // Slave: ack in the cycle after the strobe first rises.
    initial begin
        avm_waitrequest_n = 1'b0;
        avm_readdata = 8'h00;
    end
    always @(posedge clk) begin
        #1;
        if (avm_chipselect) begin
            if (!seen) begin
                seen = 1'b1;
                avm_waitrequest_n = 1'b0;
            end else if (!avm_waitrequest_n) begin
                avm_waitrequest_n = 1'b1;
                if (avm_read)
                    avm_readdata = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
            end
        end else begin
            seen = 1'b0;
            avm_waitrequest_n = spur;
        end
    end

    // Compare process
    always @(negedge clk) begin
        int k;
        int ph;
        bit e_cs;
        bit e_end;
        if (!rst_n) begin
            track = 1'b0;
            pend = 1'b0;
            chk("reset_state",
                {frame_ready, busy, avm_chipselect, avm_read, avm_write, tx_done, tx_err,
                 avm_address, avm_writedata},
                {7'b1000000, 16'h0000});
        end else begin
            if (pend) begin
                track = 1'b1;
                pend = 1'b0;
                cyc = 0;
            end
            if (track) begin
                cyc++;
                k = (cyc - 1) / 3;
                ph = (cyc - 1) % 3;
                e_cs = (ph < 2);
                e_end = (cyc == exp_len);
                chk("trace",
                    {frame_ready, busy, avm_chipselect, avm_read, avm_write, tx_done, tx_err},
                    {1'b0, 1'b1, e_cs, e_cs && !exp_wr[k], e_cs && exp_wr[k],
                     e_end && !exp_to, e_end && exp_to});
                if (e_cs)
                    chk("addr", 64'(avm_address), 64'(exp_addr[k]));
                if (e_cs && exp_wr[k])
                    chk("wdata", 64'(avm_writedata), 64'(exp_data[k]));
                if (avm_chipselect && ph == 0) begin
                    if (avm_write) wlog.push_back({avm_address, avm_writedata});
                    if (avm_read) rcount++;
                end
                if (tx_done) done_cyc = cyc;
                if (tx_err) err_cnt++;
                if (e_end) track = 1'b0;
            end else begin
                chk("idle",
                    {frame_ready, busy, avm_chipselect, avm_read, avm_write, tx_done, tx_err},
                    7'b1000000);
            end
        end
    end

    task automatic start(input logic [10:0] id, input bit rtr,
                         input logic [3:0] dlc, input logic [63:0] data);
        build(id, rtr, dlc, data);
        wlog.delete();
        rcount = 0;
        done_cyc = -1;
        err_cnt = 0;
        @(negedge clk);
        frame_id = id;
        frame_rtr = rtr;
        frame_dlc = dlc;
        frame_data = data;
        frame_valid = 1'b1;
        @(posedge clk);
        pend = 1'b1;
        #1;
        frame_valid = 1'b0;
        frame_id = ~id;
        frame_rtr = ~rtr;
        frame_dlc = ~dlc;
        frame_data = ~data;
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while ((pend || track) && i < 400) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (pend || track) begin
            failures++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, i);
            pend = 1'b0;
            track = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] e[$];
        rst_n = 1'b0;
        frame_valid = 1'b0;
        frame_id = 11'd0;
        frame_rtr = 1'b0;
        frame_dlc = 4'd0;
        frame_data = 64'd0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // data frame, first poll succeeds
        stat_q = '{8'h04};
        start(11'h123, 1'b0, 4'd2, 64'h0000_0000_0000_BBAA);
        wait_idle("t1");
        e = '{16'h0A24, 16'h0B62, 16'h0CAA, 16'h0DBB, 16'h0101};
        chk_log("t1", e);
        chk("t1_done_cycle", 64'(done_cyc), 64'd18);
        chk("t1_reads", 64'(rcount), 64'd1);

        // remote frame: no data bytes
        stat_q = '{8'h04};
        start(11'h7FF, 1'b1, 4'd4, 64'h1122_3344_5566_7788);
        wait_idle("t2");
        e = '{16'h0AFF, 16'h0BF4, 16'h0101};
        chk_log("t2", e);
        chk("t2_done_cycle", 64'(done_cyc), 64'd12);

        // DLC 15: control byte keeps F, eight data writes
        stat_q = '{8'h04};
        start(11'h000, 1'b0, 4'hF, 64'h0807_0605_0403_0201);
        wait_idle("t3");
        e = '{16'h0A00, 16'h0B0F};
        for (int b = 0; b < 8; b++)
            e.push_back({8'(12 + b), 8'(b + 1)});
        e.push_back(16'h0101);
        chk_log("t3", e);
        chk("t3_done_cycle", 64'(done_cyc), 64'd36);

        // busy buffer: three failed polls
        stat_q = '{8'h00, 8'h00, 8'h00, 8'h0C};
        start(11'h5A5, 1'b0, 4'd1, 64'h77);
        wait_idle("t4");
        e = '{16'h0AB4, 16'h0BA1, 16'h0C77, 16'h0101};
        chk_log("t4", e);
        chk("t4_reads", 64'(rcount), 64'd4);
        chk("t4_done_cycle", 64'(done_cyc), 64'd24);

        // zero-length frame with acks asserted outside any access
        spur = 1'b1;
        stat_q = '{8'h04};
        start(11'h001, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle("t5");
        e = '{16'h0A00, 16'h0B20, 16'h0101};
        chk_log("t5", e);
        chk("t5_done_cycle", 64'(done_cyc), 64'd12);
        spur = 1'b0;
        repeat (2) @(negedge clk);

        // reset while the address-12 write is held
        stat_q = '{8'h04};
        start(11'h155, 1'b0, 4'd3, 64'h33_2211);
        repeat (9) @(posedge clk);
        #2;
        chk("t6_held_strobe", {avm_chipselect, avm_write, avm_address}, {2'b11, 8'd12});
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", {avm_chipselect, avm_read, avm_write, busy}, 4'b0000);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        stat_q.delete();
        repeat (3) @(negedge clk);
        chk("t6_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_ready", 64'(frame_ready), 64'd1);

        // next frame after reset proceeds normally
        stat_q = '{8'h04};
        start(11'h2C3, 1'b0, 4'd8, 64'h8877_6655_4433_2211);
        wait_idle("t7");
        chk("t7_nwrites", 64'(wlog.size()), 64'd11);
        chk("t7_done_cycle", 64'(done_cyc), 64'd36);

`ifdef CAN_FRAME_WRITER_TIMEOUT_EN
        // status stuck at 0: bounded polling
        stat_q.delete();
        start(11'h0FF, 1'b0, 4'd1, 64'h55);
        wait_idle("t8");
        chk("t8_reads", 64'(rcount), 64'd5);
        chk("t8_nwrites", 64'(wlog.size()), 64'd0);
        chk("t8_err_pulses", 64'(err_cnt), 64'd1);
        chk("t8_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t8_ready", 64'(frame_ready), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/can_frame_writer.md
# can_frame_writer

Avalon-MM master that turns one CAN 2.0A frame, presented on a valid/ready port, into the register-access sequence the `can_controller` Avalon slave needs to transmit it. It operates in BasicCAN mode.

- It polls the status register until the transmit buffer is released.
- It loads the TX buffer with identifier, control and data bytes.
- It issues the transmission-request command.
- It sits directly upstream of `can_controller`, between frame-producing logic and the controller's `avs_*` port.

## Interface
Parameters:
- `MAX_POLLS`, default 255: status reads allowed before timeout. Used only when `CAN_FRAME_WRITER_TIMEOUT_EN` is defined. Range 1..255.

Ports:
- `csi_clk` input 1: single clock for the block and the Avalon master port.
- `rsi_reset_n` input 1: asynchronous active-low reset.
- `frame_valid` input 1: frame fields valid.
- `frame_ready` output 1: block can accept a frame. High only in IDLE.
- `frame_id` input 11: standard identifier.
- `frame_rtr` input 1: remote frame flag.
- `frame_dlc` input 4: data length code.
- `frame_data` input 64: data bytes, with byte0 in [7:0] and byte7 in [63:56].
- `avm_address` output 8: controller register address.
- `avm_chipselect` output 1: access strobe.
- `avm_write` output 1: write access.
- `avm_read` output 1: read access.
- `avm_writedata` output 8: write data.
- `avm_readdata` input 8: read data.
- `avm_waitrequest_n` input 1: access complete (ack).
- `busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse after the command write is acked.
- `tx_err` output 1: one-cycle pulse when the poll times out.

## Operation
- Frame acceptance:
  - A frame is accepted on a rising edge with `frame_valid & frame_ready`.
  - All fields are latched into internal registers at that edge.
  - Frame inputs are ignored outside IDLE.
- Effective length: n = min(`frame_dlc`, 8); n = 0 if `frame_rtr`=1. DLC values 9..15 are written unchanged into the control byte, but only 8 data bytes are written.
- States:
  - IDLE: accept a frame, go to POLL.
  - POLL: read address 2. On ack, sample `avm_readdata`: if bit 2 (TBS) = 1 go to LOAD with index 0; otherwise go to POLL_GAP.
  - POLL_GAP: one idle cycle, then back to POLL.
  - LOAD: write 2+n bytes in order.
    - Address 10 ← `id[10:3]`.
    - Address 11 ← {`id[2:0]`, rtr, dlc}.
    - Addresses 12..12+n-1 ← data bytes 0..n-1.
    - After the last byte, go to CMD.
  - CMD: write address 1 ← 8'h01 (transmission request). On ack go to DONE.
  - DONE: pulse `tx_done`, go to IDLE.
- Access protocol:
  - `avm_chipselect`, the selected `avm_read` or `avm_write`, `avm_address` and `avm_writedata` are held constant until the cycle in which `avm_waitrequest_n`=1.
  - All strobes deassert in the next cycle, and stay low for at least one cycle between accesses.
  - `avm_read` and `avm_write` are never high together.
- An ack arriving while `avm_chipselect`=0 is ignored.
- Reset mid-operation: all strobes drop asynchronously, the latched frame is discarded, state returns to IDLE, and no `tx_done` is issued.

## Timing
- Reset values:
  - `frame_ready`=1.
  - `busy`, `avm_chipselect`, `avm_read`, `avm_write`, `tx_done`, `tx_err` = 0.
  - `avm_address`, `avm_writedata` = 0.
- All outputs are registered.
- Cycle counts with a 1-cycle ack slave (ack in the cycle after the strobe first goes high), counting the accepting edge as cycle 0:
  - Access k asserts its strobe in cycle 1+3k.
  - Each access takes 3 cycles (strobe, ack, gap).
  - Each failed poll adds 3 cycles.
- Total accesses are 1+2+n+1 on a first-time poll success.
- `tx_done` is high during the gap cycle that follows the command ack.
- `frame_ready` returns high in the cycle after `tx_done`. Minimum frame-to-frame spacing is therefore 3·(4+n)+1 cycles.

## Configuration
- `CAN_FRAME_WRITER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on frame acceptance and increments on each POLL read that returns TBS=0.
  - When the counter reaches `MAX_POLLS`, the block pulses `tx_err` during POLL_GAP, drops the frame and returns to IDLE.
- Not defined:
  - POLL repeats indefinitely.
  - `tx_err` is tied to 0.
  - No counter is synthesised.

## Test plan
- Data frame, first poll succeeds: id=11'h123, dlc=2, data=16'hBBAA, status read=8'h04.
  - Required writes: 10←24, 11←62, 12←AA, 13←BB, then 1←01.
  - `tx_done` high 18 cycles after acceptance.
- RTR frame: id=11'h7FF, rtr=1, dlc=4.
  - Required writes: 10←FF, 11←F4, then 1←01.
  - No data-byte writes.
- Long DLC: dlc=4'hF, data=64'h0807060504030201.
  - Address 11 gets low nibble F.
  - Exactly 8 data writes, to addresses 12..19, with values 01..08.
- Busy buffer:
  - Status returns 8'h00 three times, then 8'h0C.
  - Bench checks 4 reads of address 2, each followed by an idle cycle with strobes low, then the normal load.
  - With the macro defined and `MAX_POLLS`=5, status stuck at 0: exactly 5 reads, one `tx_err` pulse, no writes, `frame_ready`=1.
- Reset mid-load: assert `rsi_reset_n`=0 while the strobe for address 12 is held.
  - Strobes go low with no clock edge.
  - After release: IDLE, `frame_ready`=1, no `tx_done`.
  - Next frame proceeds normally.
